// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_pkg
//  Purpose  : Shared opcode encodings and types for the alu_core datapath.
//  Revision : 1.0  initial release
// ============================================================================
package alu_pkg;

    typedef logic [2:0] op_t;

    localparam op_t OP_ADD = 3'b000;
    localparam op_t OP_SUB = 3'b001;
    localparam op_t OP_NOT = 3'b010;
    localparam op_t OP_AND = 3'b011;
    localparam op_t OP_OR  = 3'b100;
    localparam op_t OP_XOR = 3'b101;
    localparam op_t OP_SLT = 3'b110;
    localparam op_t OP_EQ  = 3'b111;

endpackage
`default_nettype wire

// File: rtl/alu_if.sv
`default_nettype none
// ============================================================================
//  Module   : alu_if
//  Purpose  : Operand/result bundle between an ALU user and alu_core.
//  Revision : 1.0  initial release
// ============================================================================
interface alu_if #(
    parameter int WIDTH = 4
);
    import alu_pkg::*;

    op_t              op;
    logic             in_c;
    logic [WIDTH-1:0] in_x;
    logic [WIDTH-1:0] in_y;
    logic [WIDTH-1:0] out_s;
    logic             out_c;
    logic             zero;
    logic             overflow;

    // Requester side: supplies the operation, observes the registered result
    modport master (
        output op, in_c, in_x, in_y,
        input  out_s, out_c, zero, overflow
    );

    // ALU side
    modport slave (
        input  op, in_c, in_x, in_y,
        output out_s, out_c, zero, overflow
    );

endinterface
`default_nettype wire

// File: rtl/alu_addsub.sv
`default_nettype none
// ============================================================================
//  Module   : alu_addsub
//  Purpose  : Shared adder/subtractor with carry-out and signed overflow.
//             sub=1 computes x + ~y + ~cin, i.e. x - y - cin.
//  Revision : 1.0  initial release
// ============================================================================
module alu_addsub #(
    parameter int WIDTH = 4
) (
    input  wire logic [WIDTH-1:0] x,
    input  wire logic [WIDTH-1:0] y,
    input  wire logic             cin,
    input  wire logic             sub,
    output logic      [WIDTH-1:0] sum,
    output logic                  cout,
    output logic                  ovf
);

    logic [WIDTH-1:0] w_y_eff;
    logic             w_c_eff;
    logic [WIDTH:0]   w_total;

    // Conditional inversion turns the adder into a subtractor
    always_comb begin
        w_y_eff = sub ? ~y : y;
        w_c_eff = sub ? ~cin : cin;
        w_total = {1'b0, x} + {1'b0, w_y_eff} + {{WIDTH{1'b0}}, w_c_eff};
        sum     = w_total[WIDTH-1:0];
        cout    = w_total[WIDTH];
        // Same-sign operands producing an opposite-sign result
        ovf     = (x[WIDTH-1] == w_y_eff[WIDTH-1]) &&
                  (w_total[WIDTH-1] != x[WIDTH-1]);
    end

endmodule
`default_nettype wire

// File: rtl/alu_core.sv
`default_nettype none
// ============================================================================
//  Module   : alu_core
//  Purpose  : Registered integer ALU, one-cycle latency, one op per cycle.
//             Produces result, carry, zero and signed-overflow flags.
//  Revision : 1.0  initial release
// ============================================================================
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  wire logic clk,
    input  wire logic rst,
    alu_if.slave      bus
);

    logic [WIDTH-1:0] w_as_sum;
    logic             w_as_cout;
    logic             w_as_ovf;
    logic             w_as_sub;
    logic             w_as_cin;
    logic             w_lt;

    logic [WIDTH-1:0] w_s;
    logic             w_c;
    logic             w_ovf;
    logic             w_zero;

    logic [WIDTH-1:0] r_s;
    logic             r_c;
    logic             r_zero;
    logic             r_ovf;

    // SLT reuses the subtractor as a plain x - y (borrow-in forced to 0)
    always_comb begin
        w_as_sub = (bus.op == OP_SUB) || (bus.op == OP_SLT);
        w_as_cin = (bus.op == OP_SLT) ? 1'b0 : bus.in_c;
    end

    alu_addsub #(
        .WIDTH (WIDTH)
    ) u_addsub (
        .x    (bus.in_x),
        .y    (bus.in_y),
        .cin  (w_as_cin),
        .sub  (w_as_sub),
        .sum  (w_as_sum),
        .cout (w_as_cout),
        .ovf  (w_as_ovf)
    );

    // True signed less-than: difference sign corrected by overflow
    assign w_lt = w_as_sum[WIDTH-1] ^ w_as_ovf;

    // Opcode mux and next-state flags
    always_comb begin
        w_s   = '0;
        w_c   = 1'b0;
        w_ovf = 1'b0;
        case (bus.op)
            OP_ADD, OP_SUB: begin
                w_s   = w_as_sum;
                w_c   = w_as_cout;
                w_ovf = w_as_ovf;
            end
            OP_NOT:  w_s = ~bus.in_x;
            OP_AND:  w_s = bus.in_x & bus.in_y;
            OP_OR:   w_s = bus.in_x | bus.in_y;
            OP_XOR:  w_s = bus.in_x ^ bus.in_y;
            OP_SLT:  w_s = {{(WIDTH-1){1'b0}}, w_lt};
            OP_EQ:   w_s = {{(WIDTH-1){1'b0}}, (bus.in_x == bus.in_y)};
            default: w_s = '0;
        endcase
        w_zero = (w_s == '0);
    end

    // Output registers; reset discards any in-flight result
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s    <= '0;
            r_c    <= 1'b0;
            r_zero <= 1'b1;
            r_ovf  <= 1'b0;
        end else begin
            r_s    <= w_s;
            r_c    <= w_c;
            r_zero <= w_zero;
            r_ovf  <= w_ovf;
        end
    end

    assign bus.out_s    = r_s;
    assign bus.out_c    = r_c;
    assign bus.zero     = r_zero;
    assign bus.overflow = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_alu_core.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_core
//  Purpose  : Self-checking bench for alu_core (WIDTH=4).
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_core;
    import alu_pkg::*;

    localparam int W = 4;
    localparam int M = 1 << W;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;

    alu_if #(.WIDTH(W)) bus ();

    alu_core #(
        .WIDTH (W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: integer arithmetic on unsigned/signed interpretations.
    // Returns {s, c, zero, ovf}.
    function automatic logic [W+2:0] model(input logic [2:0] op,
                                           input logic [W-1:0] x,
                                           input logic [W-1:0] y,
                                           input logic cin);
        int ux, uy, sx, sy, ci, tot, sres, s;
        logic c, o;
        logic [W-1:0] sv;
        ux = int'(x);
        uy = int'(y);
        sx = (ux >= M / 2) ? ux - M : ux;
        sy = (uy >= M / 2) ? uy - M : uy;
        ci = cin ? 1 : 0;
        s = 0; c = 1'b0; o = 1'b0;
        case (op)
            3'd0: begin
                tot  = ux + uy + ci;
                s    = tot % M;
                c    = (tot >= M);
                sres = sx + sy + ci;
                o    = (sres < -(M / 2)) || (sres > M / 2 - 1);
            end
            3'd1: begin
                tot  = ux + (M - 1 - uy) + (1 - ci);
                s    = tot % M;
                c    = (tot >= M);
                sres = sx - sy - ci;
                o    = (sres < -(M / 2)) || (sres > M / 2 - 1);
            end
            3'd2: s = M - 1 - ux;
            3'd3: s = ux & uy;
            3'd4: s = ux | uy;
            3'd5: s = ux ^ uy;
            3'd6: s = (sx < sy) ? 1 : 0;
            default: s = (ux == uy) ? 1 : 0;
        endcase
        sv = s[W-1:0];
        return {sv, c, (s == 0), o};
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [W-1:0] s, input logic c,
                             input logic z, input logic o);
        check({tag, ".out_s"},    bus.out_s, s);
        check({tag, ".out_c"},    {{(W-1){1'b0}}, bus.out_c}, {{(W-1){1'b0}}, c});
        check({tag, ".zero"},     {{(W-1){1'b0}}, bus.zero}, {{(W-1){1'b0}}, z});
        check({tag, ".overflow"}, {{(W-1){1'b0}}, bus.overflow}, {{(W-1){1'b0}}, o});
    endtask

    // Apply one op for one edge, then sample just after that edge
    task automatic step(input logic [2:0] op, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic cin);
        @(negedge clk);
        bus.op   = op;
        bus.in_x = x;
        bus.in_y = y;
        bus.in_c = cin;
        @(posedge clk);
        #1;
    endtask

    task automatic step_model(input string tag, input logic [2:0] op, input logic [W-1:0] x,
                              input logic [W-1:0] y, input logic cin);
        logic [W+2:0] e;
        e = model(op, x, y, cin);
        step(op, x, y, cin);
        check_all($sformatf("%s op%0d x%0h y%0h c%0d", tag, op, x, y, cin),
                  e[W+2:3], e[2], e[1], e[0]);
    endtask

    task automatic reset_cycle(input string tag);
        @(negedge clk);
        rst      = 1'b1;
        bus.op   = 3'($urandom_range(0, 7));
        bus.in_x = W'($urandom);
        bus.in_y = W'($urandom);
        bus.in_c = 1'($urandom);
        @(posedge clk);
        #1;
        check_all(tag, '0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        n_cmp    = 0;
        n_fail   = 0;
        rst      = 1'b1;
        bus.op   = OP_ADD;
        bus.in_x = '0;
        bus.in_y = '0;
        bus.in_c = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", '0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Directed cases with hand-derived expectations
        step(OP_ADD, 4'h7, 4'h1, 1'b0); check_all("add7+1",   4'h8, 1'b0, 1'b0, 1'b1);
        step(OP_ADD, 4'h7, 4'h1, 1'b1); check_all("add7+1+c", 4'h9, 1'b0, 1'b0, 1'b1);
        step(OP_ADD, 4'h8, 4'h8, 1'b0); check_all("add8+8",   4'h0, 1'b1, 1'b1, 1'b1);
        step(OP_SUB, 4'h8, 4'h1, 1'b0); check_all("sub8-1",   4'h7, 1'b1, 1'b0, 1'b1);
        step(OP_SUB, 4'h3, 4'h3, 1'b0); check_all("sub3-3",   4'h0, 1'b1, 1'b1, 1'b0);
        step(OP_NOT, 4'hC, 4'hA, 1'b1); check_all("not",      4'h3, 1'b0, 1'b0, 1'b0);
        step(OP_AND, 4'hC, 4'hA, 1'b1); check_all("and",      4'h8, 1'b0, 1'b0, 1'b0);
        step(OP_OR,  4'hC, 4'hA, 1'b0); check_all("or",       4'hE, 1'b0, 1'b0, 1'b0);
        step(OP_XOR, 4'hC, 4'hA, 1'b0); check_all("xor",      4'h6, 1'b0, 1'b0, 1'b0);
        step(OP_AND, 4'hC, 4'h3, 1'b0); check_all("and0",     4'h0, 1'b0, 1'b1, 1'b0);
        step(OP_SLT, 4'h8, 4'h7, 1'b0); check_all("slt8_7",   4'h1, 1'b0, 1'b0, 1'b0);
        step(OP_SLT, 4'h7, 4'h8, 1'b1); check_all("slt7_8",   4'h0, 1'b0, 1'b1, 1'b0);
        step(OP_EQ,  4'h5, 4'h5, 1'b0); check_all("eq5_5",    4'h1, 1'b0, 1'b0, 1'b0);
        step(OP_EQ,  4'h5, 4'h4, 1'b0); check_all("eq5_4",    4'h0, 1'b0, 1'b1, 1'b0);

        // Exhaustive sweep against the model, with a reset dropped in mid-way
        for (int op = 0; op < 8; op++) begin
            for (int x = 0; x < M; x++) begin
                for (int y = 0; y < M; y++) begin
                    for (int c = 0; c < 2; c++) begin
                        if (op == 4 && x == 2 && y == 9 && c == 0)
                            reset_cycle("midreset");
                        step_model("sweep", 3'(op), W'(x), W'(y), 1'(c));
                    end
                end
            end
        end

        // Randomized back-to-back ops
        for (int i = 0; i < 400; i++) begin
            step_model("rand", 3'($urandom_range(0, 7)), W'($urandom), W'($urandom), 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
